// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package ps2_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StParity,
    StStop
  } ps2_state_e;

  localparam logic [7:0]  PS2_BREAK_CODE = 8'hF0;
  localparam logic [7:0]  PS2_EXT_CODE   = 8'hE0;
  localparam int unsigned PS2_FRAME_BITS = 11;

endpackage

// File: rtl/ps2_input_filter.sv
// PS/2 pin conditioning: 2-flop synchronizers, kclk glitch filter and a one-cycle
// strobe on each falling edge of the filtered clock.
module ps2_input_filter #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_kclk,
  input  logic i_kdata,
  output logic o_fall,
  output logic o_kdata
);

  localparam int unsigned CntW = $clog2(FILTER_LEN + 1);

  logic            r_kclk_meta;
  logic            r_kclk_sync;
  logic            r_kdata_meta;
  logic            r_kdata_sync;
  logic            r_filt;
  logic [CntW-1:0] r_cnt;
  logic            r_fall;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_kclk_meta  <= 1'b1;
      r_kclk_sync  <= 1'b1;
      r_kdata_meta <= 1'b1;
      r_kdata_sync <= 1'b1;
      r_filt       <= 1'b1;
      r_cnt        <= '0;
      r_fall       <= 1'b0;
    end else begin
      r_kclk_meta  <= i_kclk;
      r_kclk_sync  <= r_kclk_meta;
      r_kdata_meta <= i_kdata;
      r_kdata_sync <= r_kdata_meta;
      r_fall       <= 1'b0;
      // Filtered level flips only after FILTER_LEN consecutive disagreeing samples.
      if (r_kclk_sync == r_filt) begin
        r_cnt <= '0;
      end else if (r_cnt == CntW'(FILTER_LEN - 1)) begin
        r_filt <= r_kclk_sync;
        r_cnt  <= '0;
        r_fall <= r_filt;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_fall  = r_fall;
  assign o_kdata = r_kdata_sync;

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 device-to-host frame receiver with a one-entry valid/ready output buffer.
// Optional break-code folding is enabled with PS2_RX_BREAK_DECODE_EN.
module ps2_keyboard_rx
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       kclk_i,
  input  logic       kdata_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       parity_err_o,
  output logic       frame_err_o,
  output logic       overrun_o,
  output logic       break_o
);

  localparam int unsigned TimerW = $clog2(TIMEOUT_CYCLES + 1);

  logic              w_fall;
  logic              w_kdata;
  ps2_state_e        r_state;
  ps2_state_e        w_state_d;
  logic [2:0]        r_bit_cnt;
  logic [7:0]        r_shift;
  logic              r_parity;
  logic [TimerW-1:0] r_timer;
  logic              w_timeout;
  logic              w_good;
  logic              w_parity_bad;
  logic              w_frame_bad;
  logic              w_deliver;
  logic              w_break_next;
  logic [7:0]        r_data;
  logic              r_valid;
  logic              r_parity_err;
  logic              r_frame_err;
  logic              r_overrun;

  ps2_input_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_filter (
    .i_clk  (clk_i),
    .i_rst  (rst_i),
    .i_kclk (kclk_i),
    .i_kdata(kdata_i),
    .o_fall (w_fall),
    .o_kdata(w_kdata)
  );

  assign w_timeout = (r_state != StIdle) && !w_fall &&
                     (r_timer == TimerW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:   if (w_fall && !w_kdata) w_state_d = StData;
      StData:   if (w_fall && (r_bit_cnt == 3'd7)) w_state_d = StParity;
      StParity: if (w_fall) w_state_d = StStop;
      StStop:   if (w_fall) w_state_d = StIdle;
      default:  w_state_d = StIdle;
    endcase
    if (w_timeout) w_state_d = StIdle;
  end

  // Frame verdict on the stop-bit strobe; stop-bit errors take priority over parity.
  always_comb begin
    w_good       = 1'b0;
    w_parity_bad = 1'b0;
    w_frame_bad  = w_timeout;
    if ((r_state == StStop) && w_fall) begin
      if (!w_kdata) begin
        w_frame_bad = 1'b1;
      end else if (!(^{r_shift, r_parity})) begin
        w_parity_bad = 1'b1;
      end else begin
        w_good = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_parity  <= 1'b0;
      r_timer   <= '0;
    end else begin
      if (r_state == StIdle) begin
        r_bit_cnt <= '0;
      end else if ((r_state == StData) && w_fall) begin
        r_shift   <= {w_kdata, r_shift[7:1]};
        r_bit_cnt <= r_bit_cnt + 3'd1;
      end
      if ((r_state == StParity) && w_fall) r_parity <= w_kdata;
      if ((r_state == StIdle) || w_fall) begin
        r_timer <= '0;
      end else if (r_timer != TimerW'(TIMEOUT_CYCLES - 1)) begin
        r_timer <= r_timer + 1'b1;
      end
    end
  end

`ifdef PS2_RX_BREAK_DECODE_EN
  logic w_is_break;
  logic r_break_pending;
  logic r_break;

  assign w_is_break   = w_good && (r_shift == PS2_BREAK_CODE);
  assign w_deliver    = w_good && !w_is_break;
  assign w_break_next = r_break_pending && (r_shift != PS2_EXT_CODE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_break_pending <= 1'b0;
    end else if (w_frame_bad || w_parity_bad) begin
      r_break_pending <= 1'b0;
    end else if (w_is_break) begin
      r_break_pending <= 1'b1;
    end else if (w_deliver && (r_shift != PS2_EXT_CODE)) begin
      r_break_pending <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_break <= 1'b0;
    end else if (w_deliver && (!r_valid || ready_i)) begin
      r_break <= w_break_next;
    end
  end

  assign break_o = r_break;
`else
  assign w_deliver    = w_good;
  assign w_break_next = 1'b0;
  assign break_o      = w_break_next;
`endif

  // A byte arriving during the accepting handshake replaces the old one without overrun.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_data       <= '0;
      r_valid      <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_parity_err <= w_parity_bad;
      r_frame_err  <= w_frame_bad;
      r_overrun    <= w_deliver && r_valid && !ready_i;
      if (w_deliver && (!r_valid || ready_i)) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
      end else if (r_valid && ready_i) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign data_o       = r_data;
  assign valid_o      = r_valid;
  assign parity_err_o = r_parity_err;
  assign frame_err_o  = r_frame_err;
  assign overrun_o    = r_overrun;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Scoreboard bench for ps2_keyboard_rx; expectations follow PS2_RX_BREAK_DECODE_EN if defined.
module tb_ps2_keyboard_rx;

  localparam int unsigned FilterLen = 8;
  localparam int unsigned Timeout   = 500;
  localparam int          Half      = 40;
  localparam int          EvParity  = 1;
  localparam int          EvFrame   = 2;
  localparam int          EvOverrun = 3;

  typedef struct packed {
    logic [7:0] data;
    logic       brk;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       kclk;
  logic       kdata;
  logic       ready;
  logic [7:0] data_o;
  logic       valid_o;
  logic       parity_err_o;
  logic       frame_err_o;
  logic       overrun_o;
  logic       break_o;

  exp_t data_q[$];
  int   evt_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   t_valid  = -1;
  int   t_stop   = 0;
  logic prev_valid = 1'b0;
  bit   m_pend   = 1'b0;

  ps2_keyboard_rx #(
    .FILTER_LEN    (FilterLen),
    .TIMEOUT_CYCLES(Timeout)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .kclk_i      (kclk),
    .kdata_i     (kdata),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .ready_i     (ready),
    .parity_err_o(parity_err_o),
    .frame_err_o (frame_err_o),
    .overrun_o   (overrun_o),
    .break_o     (break_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic expect_evt(input int kind);
    if (evt_q.size() == 0) check("evt_unexpected", evt_q.size(), 1);
    else check("evt_kind", kind, evt_q.pop_front());
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (valid_o && !prev_valid) t_valid = cyc;
      prev_valid = valid_o;
      if (valid_o && ready) begin
        if (data_q.size() == 0) begin
          check("byte_unexpected", data_q.size(), 1);
        end else begin
          e = data_q.pop_front();
          check("data", data_o, e.data);
          check("break", break_o, e.brk);
        end
      end
      if (parity_err_o) expect_evt(EvParity);
      if (frame_err_o) expect_evt(EvFrame);
      if (overrun_o) expect_evt(EvOverrun);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic kbit(input logic b);
    kdata = b;
    tick(Half);
    kclk = 1'b0;
    tick(Half);
    kclk = 1'b1;
  endtask

  task automatic model_push(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic brk;
    brk = 1'b0;
    if (bad_stop) begin
      evt_q.push_back(EvFrame);
      m_pend = 1'b0;
    end else if (bad_par) begin
      evt_q.push_back(EvParity);
      m_pend = 1'b0;
    end else begin
`ifdef PS2_RX_BREAK_DECODE_EN
      if (b == 8'hF0) begin
        m_pend = 1'b1;
        return;
      end
      if (b != 8'hE0) begin
        brk    = m_pend;
        m_pend = 1'b0;
      end
`endif
      if (!ready && (data_q.size() > 0)) evt_q.push_back(EvOverrun);
      else data_q.push_back(exp_t'{data: b, brk: brk});
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par = 0, input bit bad_stop = 0);
    kbit(1'b0);
    for (int i = 0; i < 8; i++) kbit(b[i]);
    kbit((~^b) ^ bad_par);
    model_push(b, bad_par, bad_stop);
    kdata = ~bad_stop;
    tick(Half);
    t_stop = cyc;
    kclk = 1'b0;
    tick(Half);
    kclk  = 1'b1;
    kdata = 1'b1;
    tick(Half);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 3000 && (data_q.size() != 0 || evt_q.size() != 0); i++) tick(1);
    tick(10);
    check("drain_data", data_q.size(), 0);
    check("drain_evt", evt_q.size(), 0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_data"}, data_o, 0);
    check({tag, "_valid"}, valid_o, 0);
    check({tag, "_break"}, break_o, 0);
    check({tag, "_perr"}, parity_err_o, 0);
    check({tag, "_ferr"}, frame_err_o, 0);
    check({tag, "_ovr"}, overrun_o, 0);
  endtask

  initial begin
    rst   = 1'b1;
    kclk  = 1'b1;
    kdata = 1'b1;
    ready = 1'b1;
    tick(5);
    check_idle_outputs("reset");
    rst = 1'b0;
    tick(20);

    send_frame(8'h1C);
    wait_drain();
    check("latency_in_range", ((t_valid - t_stop) >= 11) && ((t_valid - t_stop) <= 13), 1);

    send_frame(8'h00, 1, 0);
    send_frame(8'h1C, 0, 1);
    wait_drain();

    // Stall mid-frame long enough to trip the timeout.
    kbit(1'b0);
    for (int i = 0; i < 4; i++) kbit(i[0]);
    evt_q.push_back(EvFrame);
    m_pend = 1'b0;
    tick(Timeout + 100);
    send_frame(8'h32);
    wait_drain();

    ready = 1'b0;
    send_frame(8'h1C);
    send_frame(8'h32);
    tick(20);
    check("hold_valid", valid_o, 1);
    check("hold_data", data_o, 8'h1C);
    ready = 1'b1;
    tick(1);
    check("valid_after_accept", valid_o, 0);
    wait_drain();

    for (int i = 0; i < 4; i++) begin
      kclk = 1'b0;
      tick(3);
      kclk = 1'b1;
      tick(30);
    end
    kbit(1'b0);
    kbit(1'b1);
    kbit(1'b0);
    kdata = 1'b1;
    rst   = 1'b1;
    m_pend = 1'b0;
    tick(3);
    check_idle_outputs("midreset");
    rst = 1'b0;
    tick(Half);
    send_frame(8'h45);
    wait_drain();

    send_frame(8'hF0);
    send_frame(8'h1C);
    send_frame(8'hF0);
    send_frame(8'hE0);
    send_frame(8'h74);
    send_frame(8'hF0);
    send_frame(8'h12, 1, 0);
    send_frame(8'h1C);
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_keyboard_rx.md
Name: ps2_keyboard_rx

Overview:
PS/2 keyboard receiver, the input-side counterpart of the board's seven-segment output path.
- Takes the raw PS/2 clock/data pins from the board and recovers 11-bit device-to-host frames.
- Checks framing and parity; presents each scan-code byte on a valid/ready interface.
- Board wrapper feeds the bytes into the processor's input path (e.g. hex-entry logic driving sw_i), so programs can be entered from a keyboard instead of switches.

Parameters:
FILTER_LEN, 8, consecutive equal synchronized samples required before the filtered kclk changes level (glitch filter, clk_i cycles).
TIMEOUT_CYCLES, 100000, max clk_i cycles between kclk falling edges inside a frame before abort (1 ms at 100 MHz).

Ports:
clk_i  input  1  system clock (100 MHz on board)
rst_i  input  1  synchronous reset, active-high
kclk_i  input  1  PS/2 clock pin, asynchronous, idle high
kdata_i  input  1  PS/2 data pin, asynchronous, idle high
data_o  output  8  received byte, held stable while valid_o=1
valid_o  output  1  byte available; held until accepted
ready_i  input  1  consumer accepts byte when valid_o&&ready_i
parity_err_o  output  1  one-cycle pulse: frame discarded, bad odd parity
frame_err_o  output  1  one-cycle pulse: frame discarded, bad stop bit or timeout
overrun_o  output  1  one-cycle pulse: good frame dropped, buffer still full
break_o  output  1  qualifies data_o (only with PS2_RX_BREAK_DECODE_EN, else tied 0)

Behaviour:
- Reset: clock and reset are decided as one clock, clk_i; reset rst_i is synchronous and active-high. On reset, all outputs are 0, FSM is IDLE, and the filter state is 1 (idle high).
- Input conditioning:
  - kclk_i and kdata_i each pass through a 2-flop synchronizer.
  - kclk then passes through the FILTER_LEN glitch filter.
  - A falling edge of filtered kclk produces a one-cycle fall strobe.
  - Synchronized kdata is sampled on the fall strobe.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on fall with data=0 (start bit), go to DATA with bit_cnt=0. On fall with data=1, stay in IDLE and flag nothing.
  - DATA: each fall shifts the data bit in LSB-first. After the 8th bit (bit_cnt=7), go to PARITY.
  - PARITY: on fall, store the parity bit and go to STOP.
  - STOP: on fall, always return to IDLE, then evaluate in order:
    - stop bit=0: frame_err_o pulse;
    - else XOR(data, parity)=0: parity_err_o pulse;
    - else byte good.
- Timeout counter:
  - Clears on every fall and whenever the FSM is in IDLE.
  - If it reaches TIMEOUT_CYCLES in a non-IDLE state: return to IDLE, pulse frame_err_o, discard partial data.
- Output buffer (one entry):
  - A good byte loads data_o and sets valid_o in the cycle after the stop-bit fall strobe.
  - valid_o clears in the cycle after valid_o&&ready_i.
  - Good byte while valid_o=1 and ready_i=0: byte dropped, data_o unchanged, overrun_o pulse.
  - Good byte in the same cycle as an accepting handshake: new byte loads, valid_o stays 1, no overrun.
  - Error pulses never alter data_o or valid_o.
- Latency from kclk_i pin falling to valid_o: 2 sync + FILTER_LEN + 2 cycles, ±1 cycle.
- Reset mid-frame: frame abandoned, no error pulse. The next start bit is received normally.

Optional Feature:
Macro PS2_RX_BREAK_DECODE_EN.
- Defined:
  - A good byte 8'hF0 is not delivered; it sets an internal break_pending flag.
  - The next good byte is delivered with break_o=1 and clears the flag.
  - 8'hE0 is delivered normally and does not clear break_pending.
  - A parity or frame error clears break_pending.
  - break_o is registered alongside data_o.
- Undefined: every good byte is delivered raw, including F0; break_o is constant 0 and no flag logic exists.

Decomposition:
- Package ps2_pkg:
  - FSM state enum (IDLE, DATA, PARITY, STOP);
  - constants PS2_BREAK_CODE=8'hF0, PS2_EXT_CODE=8'hE0, PS2_FRAME_BITS=11.
- Sub-module ps2_input_filter: synchronizers, glitch filter, fall strobe and synchronized data output. It is instanced once in ps2_keyboard_rx.

Test Plan:
- Frame 0x1C (bits 0,00111000,parity 0,stop 1) at a 12.5 kHz kclk, ready_i=1 → one valid_o cycle, data_o=8'h1C, no error pulses.
- Frame 0x00 with parity 0 (wrong) → parity_err_o single pulse; valid_o stays 0.
- Frame 0x1C with stop bit 0 → frame_err_o pulse. Then kclk stopped after 4 data bits for 1.1 ms → frame_err_o pulse, FSM back in IDLE, next frame 0x32 received correctly.
- ready_i=0, frames 0x1C then 0x32 → data_o=8'h1C, valid_o=1, overrun_o pulse after the second frame. Raise ready_i → valid_o falls next cycle.
- 3-cycle low glitches on kclk_i during idle, and rst_i asserted mid-frame → no bytes, no error pulses, all outputs 0 after reset. A subsequent frame 0x45 is received.
- With PS2_RX_BREAK_DECODE_EN: frames F0, 1C → a single delivery, data_o=8'h1C, break_o=1. Without the macro: two deliveries, F0 then 1C, break_o=0.
